// File: rtl/dp_seq_pkg.sv
// dp_sequencer shared types: FSM states, command/ALU encodings,
// and the strobe bundle passed from the output decoder to the top.
package dp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRIMM,
    LDA,
    LDB,
    EXEC,
    WB,
    NOP
  } state_t;

  typedef enum logic [1:0] {
    OP_MOV_IMM = 2'b00,
    OP_MOV_REG = 2'b01,
    OP_ALU     = 2'b10,
    OP_RSVD    = 2'b11
  } cmd_op_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_CMP = 2'b01,
    ALU_AND = 2'b10,
    ALU_MVN = 2'b11
  } alu_op_t;

  localparam logic VSEL_IMM = 1'b1;
  localparam logic VSEL_C   = 1'b0;

  typedef struct packed {
    logic write;
    logic vsel;
    logic loada;
    logic loadb;
    logic asel;
    logic loadc;
    logic loads;
    logic done;
    logic sel_rn;
    logic force_add;
  } strobe_t;

endpackage

// File: rtl/dp_seq_outdec.sv
// Moore decode of sequencer state plus latched command into
// datapath strobes.
module dp_seq_outdec
  import dp_seq_pkg::*;
(
  input  state_t  state_i,
  input  cmd_op_t op_i,
  input  alu_op_t aluop_i,
  output strobe_t strb_o
);

  always_comb begin
    strb_o = '0;
    unique case (state_i)
      IDLE: ;
      WRIMM: begin
        strb_o.write = 1'b1;
        strb_o.vsel  = VSEL_IMM;
        strb_o.done  = 1'b1;
      end
      LDA: begin
        strb_o.loada  = 1'b1;
        strb_o.sel_rn = 1'b1;
      end
      LDB: strb_o.loadb = 1'b1;
      EXEC: begin
        if (op_i == OP_MOV_REG) begin
          strb_o.asel      = 1'b1;
          strb_o.loadc     = 1'b1;
          strb_o.force_add = 1'b1;
        end else if (aluop_i == ALU_CMP) begin
          strb_o.loads = 1'b1;
          strb_o.done  = 1'b1;
        end else begin
          strb_o.loadc = 1'b1;
          strb_o.loads = 1'b1;
        end
      end
      WB: begin
        strb_o.write = 1'b1;
        strb_o.vsel  = VSEL_C;
        strb_o.done  = 1'b1;
      end
      NOP: strb_o.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/dp_sequencer.sv
// Multi-cycle controller stepping the lab datapath through
// operand read, execute and write-back for one command at a time.
module dp_sequencer
  import dp_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        cmd_aluop,
  input  logic [1:0]        cmd_shift,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_rn,
  input  logic [REG_AW-1:0] cmd_rm,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [REG_AW-1:0] readnum,
  output logic [REG_AW-1:0] writenum,
  output logic              write,
  output logic              vsel,
  output logic [DATA_W-1:0] imm_out,
  output logic              loada,
  output logic              loadb,
  output logic              asel,
  output logic              bsel,
  output logic              loadc,
  output logic              loads,
  output logic [1:0]        aluop,
  output logic [1:0]        shift,
  output logic              done
);

  state_t              state_q, state_d;
  cmd_op_t             op_q;
  alu_op_t             aluop_q;
  logic [1:0]          shift_q;
  logic [REG_AW-1:0]   rd_q, rn_q, rm_q;
  logic [DATA_W-1:0]   imm_q;
  logic                accept;
  strobe_t             strb;

  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op_t'(cmd_op))
            OP_MOV_IMM: state_d = WRIMM;
            OP_MOV_REG: state_d = LDB;
            OP_ALU:     state_d = LDA;
            OP_RSVD:    state_d = NOP;
            default:    state_d = NOP;
          endcase
        end
      end
      LDA:  state_d = LDB;
      LDB:  state_d = EXEC;
      // CMP only updates status, so it skips write-back
      EXEC: state_d = (op_q == OP_ALU && aluop_q == ALU_CMP)
                      ? IDLE : WB;
      WRIMM, WB, NOP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_MOV_IMM;
      aluop_q <= ALU_ADD;
      shift_q <= '0;
      rd_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= cmd_op_t'(cmd_op);
        aluop_q <= alu_op_t'(cmd_aluop);
        shift_q <= cmd_shift;
        rd_q    <= cmd_rd;
        rn_q    <= cmd_rn;
        rm_q    <= cmd_rm;
        imm_q   <= cmd_imm;
      end
    end
  end

  dp_seq_outdec u_outdec (
    .state_i (state_q),
    .op_i    (op_q),
    .aluop_i (aluop_q),
    .strb_o  (strb)
  );

  assign write    = strb.write;
  assign vsel     = strb.vsel;
  assign loada    = strb.loada;
  assign loadb    = strb.loadb;
  assign asel     = strb.asel;
  assign bsel     = 1'b0;
  assign loadc    = strb.loadc;
  assign loads    = strb.loads;
  assign done     = strb.done;
  assign readnum  = strb.sel_rn ? rn_q : rm_q;
  assign writenum = rd_q;
  assign imm_out  = imm_q;
  assign aluop    = strb.force_add ? ALU_ADD : aluop_q;
  assign shift    = shift_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// Bench for dp_sequencer: a behavioural datapath driven by the DUT
// strobes, checked against an architectural register-file model.
module tb_dp_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op, cmd_aluop, cmd_shift;
  logic [2:0]  cmd_rd, cmd_rn, cmd_rm;
  logic [15:0] cmd_imm;
  logic [2:0]  readnum, writenum;
  logic        write, vsel, loada, loadb, asel, bsel;
  logic        loadc, loads, done;
  logic [15:0] imm_out;
  logic [1:0]  aluop, shift;

  int total = 0;
  int bad   = 0;

  logic [15:0] rf [8];
  logic [15:0] ref_rf [8];
  logic [15:0] a_r, b_r, c_r;
  logic [7:0]  obs;

  assign obs = {write, vsel, loada, loadb, asel, loadc, loads, done};

  always #5 clk = ~clk;

  dp_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_aluop(cmd_aluop), .cmd_shift(cmd_shift),
    .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_imm(cmd_imm),
    .readnum(readnum), .writenum(writenum), .write(write),
    .vsel(vsel), .imm_out(imm_out),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
    .loadc(loadc), .loads(loads),
    .aluop(aluop), .shift(shift), .done(done)
  );

  function automatic logic [15:0] shf(input logic [15:0] v,
                                      input logic [1:0] s);
    case (s)
      2'd0: return v;
      2'd1: return v << 1;
      2'd2: return v >> 1;
      default: return {v[15], v[15:1]};
    endcase
  endfunction

  function automatic logic [15:0] alu(input logic [15:0] a,
                                      input logic [15:0] b,
                                      input logic [1:0] op);
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: return a & b;
      default: return ~b;
    endcase
  endfunction

  // lab datapath: regfile, A/B, shifter on B, ALU, C
  always @(posedge clk) begin
    if (write) rf[writenum] <= vsel ? imm_out : c_r;
    if (loada) a_r <= rf[readnum];
    if (loadb) b_r <= rf[readnum];
    if (loadc) c_r <= alu(asel ? 16'h0 : a_r, shf(b_r, shift), aluop);
  end

  function automatic void ref_apply(input logic [1:0] op,
      input logic [1:0] al, input logic [1:0] sh,
      input logic [2:0] d, input logic [2:0] n,
      input logic [2:0] m, input logic [15:0] im);
    case (op)
      2'd0: ref_rf[d] = im;
      2'd1: ref_rf[d] = shf(ref_rf[m], sh);
      2'd2: if (al != 2'd1) ref_rf[d] = alu(ref_rf[n], shf(ref_rf[m], sh), al);
      default: ;
    endcase
  endfunction

  // issue one command; returns at mid-cycle of its first state
  task automatic send(input logic [1:0] op, input logic [1:0] al,
      input logic [1:0] sh, input logic [2:0] d,
      input logic [2:0] n, input logic [2:0] m,
      input logic [15:0] im);
    int t = 0;
    while (cmd_ready !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready got=%b want=1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op = op; cmd_aluop = al; cmd_shift = sh;
    cmd_rd = d; cmd_rn = n; cmd_rm = m; cmd_imm = im;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_aluop = 2'($urandom);
    cmd_shift = 2'($urandom); cmd_rd = 3'($urandom);
    cmd_rn = 3'($urandom); cmd_rm = 3'($urandom);
    cmd_imm = 16'($urandom);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs !== 8'h00) begin
      bad++; $display("FAIL reset_strobes got=%b want=00000000", obs);
    end
    total++;
    if ({readnum, writenum, imm_out, aluop, shift, bsel} !== '0) begin
      bad++;
      $display("FAIL reset_fields rn=%0d wn=%0d imm=%h al=%0d sh=%0d",
               readnum, writenum, imm_out, aluop, shift);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || obs !== 8'h00) begin
      bad++;
      $display("FAIL reset_release ready=%b strobes=%b want 1/0",
               cmd_ready, obs);
    end
  endtask

  task automatic test_mov_imm();
    send(2'd0, 2'd0, 2'd0, 3'd3, 3'd0, 3'd0, 16'h0042);
    ref_apply(2'd0, 2'd0, 2'd0, 3'd3, 3'd0, 3'd0, 16'h0042);
    total++;
    if (obs !== 8'b1100_0001 || writenum !== 3'd3 || imm_out !== 16'h0042) begin
      bad++;
      $display("FAIL movimm_wr strobes=%b wn=%0d imm=%h want 11000001/3/0042",
               obs, writenum, imm_out);
    end
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || obs !== 8'h00) begin
      bad++;
      $display("FAIL movimm_idle ready=%b strobes=%b", cmd_ready, obs);
    end
    total++;
    if (rf[3] !== 16'h0042) begin
      bad++; $display("FAIL movimm_r3 got=%h want=0042", rf[3]);
    end
  endtask

  task automatic test_alu_add();
    send(2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 16'd5);
    ref_apply(2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 16'd5);
    send(2'd0, 2'd0, 2'd0, 3'd1, 3'd0, 3'd0, 16'd7);
    ref_apply(2'd0, 2'd0, 2'd0, 3'd1, 3'd0, 3'd0, 16'd7);
    send(2'd2, 2'd0, 2'd0, 3'd2, 3'd0, 3'd1, 16'h0);
    ref_apply(2'd2, 2'd0, 2'd0, 3'd2, 3'd0, 3'd1, 16'h0);
    total++;
    if (obs !== 8'b0010_0000 || readnum !== 3'd0) begin
      bad++; $display("FAIL add_lda strobes=%b rn=%0d", obs, readnum);
    end
    @(negedge clk);
    total++;
    if (obs !== 8'b0001_0000 || readnum !== 3'd1) begin
      bad++; $display("FAIL add_ldb strobes=%b rn=%0d", obs, readnum);
    end
    @(negedge clk);
    total++;
    if (obs !== 8'b0000_0110 || aluop !== 2'd0) begin
      bad++; $display("FAIL add_exec strobes=%b al=%0d", obs, aluop);
    end
    @(negedge clk);
    total++;
    if (obs !== 8'b1000_0001 || writenum !== 3'd2) begin
      bad++; $display("FAIL add_wb strobes=%b wn=%0d", obs, writenum);
    end
    @(negedge clk);
    total++;
    if (rf[2] !== 16'd12 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL add_r2 got=%0d ready=%b want 12/1", rf[2], cmd_ready);
    end
  endtask

  task automatic test_cmp();
    int wr = 0;
    int diff = 0;
    send(2'd2, 2'd1, 2'd0, 3'd5, 3'd0, 3'd1, 16'h0);
    wr += int'(write);
    total++;
    if (obs !== 8'b0010_0000) begin
      bad++; $display("FAIL cmp_lda strobes=%b", obs);
    end
    @(negedge clk);
    wr += int'(write);
    @(negedge clk);
    wr += int'(write);
    total++;
    if (obs !== 8'b0000_0011 || aluop !== 2'd1) begin
      bad++; $display("FAIL cmp_exec strobes=%b al=%0d want 00000011/1", obs, aluop);
    end
    @(negedge clk);
    wr += int'(write);
    for (int i = 0; i < 8; i++) if (rf[i] !== ref_rf[i]) diff++;
    total++;
    if (wr != 0 || diff != 0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL cmp_nowrite writes=%0d regdiff=%0d ready=%b want 0/0/1",
               wr, diff, cmd_ready);
    end
  endtask

  task automatic test_mov_reg();
    send(2'd0, 2'd0, 2'd0, 3'd1, 3'd0, 3'd0, 16'h0003);
    ref_apply(2'd0, 2'd0, 2'd0, 3'd1, 3'd0, 3'd0, 16'h0003);
    send(2'd1, 2'd3, 2'd1, 3'd4, 3'd6, 3'd1, 16'h0);
    ref_apply(2'd1, 2'd3, 2'd1, 3'd4, 3'd6, 3'd1, 16'h0);
    total++;
    if (obs !== 8'b0001_0000 || readnum !== 3'd1) begin
      bad++; $display("FAIL movreg_ldb strobes=%b rn=%0d", obs, readnum);
    end
    @(negedge clk);
    total++;
    if (obs !== 8'b0000_1100 || aluop !== 2'd0 || shift !== 2'd1) begin
      bad++;
      $display("FAIL movreg_exec strobes=%b al=%0d sh=%0d want 00001100/0/1",
               obs, aluop, shift);
    end
    @(negedge clk);
    total++;
    if (obs !== 8'b1000_0001 || writenum !== 3'd4) begin
      bad++; $display("FAIL movreg_wb strobes=%b wn=%0d", obs, writenum);
    end
    @(negedge clk);
    total++;
    if (rf[4] !== 16'h0006) begin
      bad++; $display("FAIL movreg_r4 got=%h want=0006", rf[4]);
    end
  endtask

  task automatic test_reset_mid_wb();
    logic [15:0] old;
    old = ref_rf[5];
    send(2'd2, 2'd0, 2'd0, 3'd5, 3'd0, 3'd1, 16'h0);
    repeat (3) @(negedge clk);
    total++;
    if (write !== 1'b1) begin
      bad++; $display("FAIL rstwb_inwb write=%b want=1", write);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (write !== 1'b0 || done !== 1'b0 || obs !== 8'h00) begin
      bad++; $display("FAIL rstwb_drop write=%b strobes=%b want 0", write, obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (rf[5] !== old || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstwb_keep r5=%h want=%h ready=%b", rf[5], old, cmd_ready);
    end
    send(2'd2, 2'd0, 2'd0, 3'd5, 3'd0, 3'd1, 16'h0);
    ref_apply(2'd2, 2'd0, 2'd0, 3'd5, 3'd0, 3'd1, 16'h0);
    repeat (4) @(negedge clk);
    total++;
    if (rf[5] !== ref_rf[5]) begin
      bad++; $display("FAIL rstwb_next r5=%h want=%h", rf[5], ref_rf[5]);
    end
  endtask

  task automatic test_random();
    logic [1:0] op, al, sh;
    logic [2:0] d, n, m;
    logic [15:0] im;
    logic [7:0] ev [4];
    logic [2:0] er [4];
    int nc;
    int diff;
    for (int c = 0; c < 60; c++) begin
      op = 2'($urandom); al = 2'($urandom); sh = 2'($urandom);
      d = 3'($urandom); n = 3'($urandom); m = 3'($urandom);
      im = 16'($urandom);
      for (int k = 0; k < 4; k++) begin ev[k] = '0; er[k] = '0; end
      case (op)
        2'd0: begin ev[0] = 8'b1100_0001; nc = 1; end
        2'd1: begin
          ev[0] = 8'b0001_0000; er[0] = m;
          ev[1] = 8'b0000_1100;
          ev[2] = 8'b1000_0001; nc = 3;
        end
        2'd2: begin
          ev[0] = 8'b0010_0000; er[0] = n;
          ev[1] = 8'b0001_0000; er[1] = m;
          if (al == 2'd1) begin
            ev[2] = 8'b0000_0011; nc = 3;
          end else begin
            ev[2] = 8'b0000_0110;
            ev[3] = 8'b1000_0001; nc = 4;
          end
        end
        default: begin ev[0] = 8'b0000_0001; nc = 1; end
      endcase
      send(op, al, sh, d, n, m, im);
      ref_apply(op, al, sh, d, n, m, im);
      for (int k = 0; k < nc; k++) begin
        if (k > 0) @(negedge clk);
        total++;
        if (obs !== ev[k] || bsel !== 1'b0) begin
          bad++;
          $display("FAIL rnd_strobe cmd=%0d op=%0d al=%0d cyc=%0d got=%b want=%b",
                   c, op, al, k, obs, ev[k]);
        end
        if (ev[k][5] | ev[k][4]) begin
          total++;
          if (readnum !== er[k]) begin
            bad++;
            $display("FAIL rnd_readnum cmd=%0d cyc=%0d got=%0d want=%0d",
                     c, k, readnum, er[k]);
          end
        end
        if (ev[k][7]) begin
          total++;
          if (writenum !== d || (op == 2'd0 && imm_out !== im)) begin
            bad++;
            $display("FAIL rnd_write cmd=%0d wn=%0d want=%0d imm=%h want=%h",
                     c, writenum, d, imm_out, im);
          end
        end
        if (ev[k][2] | ev[k][1]) begin
          total++;
          if (aluop !== (op == 2'd1 ? 2'd0 : al) || shift !== sh) begin
            bad++;
            $display("FAIL rnd_exec cmd=%0d al=%0d sh=%0d want %0d/%0d",
                     c, aluop, shift, (op == 2'd1 ? 2'd0 : al), sh);
          end
        end
      end
      @(negedge clk);
      diff = 0;
      for (int i = 0; i < 8; i++) if (rf[i] !== ref_rf[i]) diff++;
      total++;
      if (diff != 0 || cmd_ready !== 1'b1 || obs !== 8'h00) begin
        bad++;
        $display("FAIL rnd_end cmd=%0d regdiff=%0d ready=%b strobes=%b",
                 c, diff, cmd_ready, obs);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      rf[i] = '0;
      ref_rf[i] = '0;
    end
    a_r = '0; b_r = '0; c_r = '0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0; cmd_aluop = '0; cmd_shift = '0;
    cmd_rd = '0; cmd_rn = '0; cmd_rm = '0; cmd_imm = '0;
    @(negedge clk);
    test_reset();
    test_mov_imm();
    test_alu_add();
    test_cmp();
    test_mov_reg();
    test_reset_mid_wb();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
